nios_sys_nios2_cpu_debug_mon_mem: RTL and testbench
===================================================

# nios_sys_nios2_cpu_debug_mon_mem

Debug monitor memory and handshake block for the Nios II debug path. It sits directly downstream of the debug-slave system-clock stage. It consumes that stage's `jdo` word and `take_action_ocimem_*` strobes to read or write a 256×32 on-chip monitor RAM through an auto-incrementing address register. It also serves the same RAM and a ready/error control register to the CPU over an Avalon-MM slave, and returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave.

## Interface
- `RAM_WORDS`, default 256: monitor RAM depth in 32-bit words. Fixed at 256 because the address fields are 8 bits.
- `clk` in 1: single system clock; every register is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset. This is the only reset.
- `jdo` in 38: command/data word from the debug slave; sampled only in a strobe cycle.
- `take_action_ocimem_a` in 1: one-cycle strobe; address/control command.
- `take_no_action_ocimem_a` in 1: one-cycle strobe; read-next command.
- `take_action_ocimem_b` in 1: one-cycle strobe; write-next command.
- `address` in 9: CPU word address. `address[8]=0` selects RAM; `address[8]=1` selects the control register.
- `read` in 1: CPU read request. Held until `waitrequest=0`.
- `write` in 1: CPU write request. Held until `waitrequest=0`.
- `writedata` in 32: CPU write data.
- `byteenable` in 4: CPU byte lanes for RAM writes.
- `readdata` out 32: CPU read data; valid in the cycle `waitrequest=0` with `read=1`.
- `waitrequest` out 1: CPU stall.
- `MonDReg` out 32: last word read by JTAG.
- `monitor_ready` out 1: CPU monitor has reached its ready point.
- `monitor_error` out 1: CPU monitor reports an error.

## Operation
- **Reset values:** `MonDReg=0`, `monitor_ready=0`, `monitor_error=0`, `readdata=0`. Internal `MonAReg=0`, `ram_owner=CPU`, CPU FSM in `C_IDLE`.
- **RAM:** single port, synchronous read with 1-cycle latency, registered output. `ram_owner` is a 1-bit register that records who addressed the RAM in the previous cycle (JTAG or CPU). The RAM content is not reset.
- **JTAG has priority.** Any JTAG strobe drives the RAM port in that same cycle.
- **`take_action_ocimem_a`:**
  - `MonAReg <= jdo[25:18]`.
  - If `jdo[17]=1`: read RAM at `jdo[25:18]` and set `MonAReg <= jdo[25:18]+1`.
  - If `jdo[34]=1`: clear `monitor_ready`.
  - If `jdo[35]=1`: clear `monitor_error`.
- **`take_no_action_ocimem_a`:** read RAM at `MonAReg`; `MonAReg <= MonAReg+1`.
- **`take_action_ocimem_b`:** write `jdo[34:3]` (all four bytes) to RAM at `MonAReg`; `MonAReg <= MonAReg+1`.
- **JTAG read capture:** in the cycle after a JTAG read issue (`ram_owner=JTAG`), `MonDReg <= RAM output`.
- **Address arithmetic:** `MonAReg` is 8 bits and wraps from 0xFF to 0x00.
- **Strobe conflicts:** the strobes are mutually exclusive by construction. If more than one is asserted, priority is `ocimem_b` > `ocimem_a` > `no_action_a`.
- **CPU FSM: `C_IDLE`, `C_RD`.**
  - `C_IDLE` with `read=1`:
    - If no JTAG strobe: present `address` to the RAM (or select the control register), set `waitrequest=1`, go to `C_RD`.
    - If a JTAG strobe is present: `waitrequest=1`, stay in `C_IDLE` and retry next cycle.
  - `C_RD`: `readdata <=` RAM output (when `ram_owner=CPU`) or `{30'b0, monitor_error, monitor_ready}`. Set `waitrequest=0`, go to `C_IDLE`. A JTAG strobe in this cycle does not disturb the CPU result.
  - `C_IDLE` with `write=1` to RAM:
    - If no JTAG strobe: byte-enabled write, `waitrequest=0`.
    - If a JTAG strobe is present: `waitrequest=1` and retry.
  - Control-register writes never stall, since they do not use the RAM: `writedata[0]=1` sets `monitor_ready`; `writedata[1]=1` sets `monitor_error`.
- **Set vs clear:** if a CPU set and a JTAG clear of the same bit occur in the same cycle, set wins.
- **`waitrequest`** is combinational. When `read=0` and `write=0`, it is 0.

## Timing
- JTAG write: strobe in cycle N; the RAM is updated at the end of N; `MonAReg` is incremented at the end of N.
- JTAG read: strobe in N; RAM output valid in N+1; `MonDReg` updated at the end of N+1 and visible from N+2.
- Back-to-back JTAG strobes in consecutive cycles are fully supported: each read captures its own data one cycle later.
- CPU read latency: 2 cycles with no conflict; each colliding JTAG strobe in `C_IDLE` adds 1 cycle.
- CPU RAM write: 1 cycle with no conflict.
- Asserting `reset_n` mid-operation returns everything to reset values immediately; a pending CPU read is abandoned.

## Test plan
- Reset, then `ocimem_a` with `jdo[25:18]=0x10`, `jdo[17]=0`, then `ocimem_b` with `jdo[34:3]=0xDEADBEEF` → RAM[0x10]=0xDEADBEEF, `MonAReg=0x11`. A CPU read at address 0x010 returns 0xDEADBEEF with `waitrequest` high for exactly 1 cycle.
- CPU writes RAM[0x20]=0x12345678. Then `ocimem_a` with address 0x20 and `jdo[17]=1` → `MonDReg=0x12345678` two cycles after the strobe, `MonAReg=0x21`. A following `take_no_action_ocimem_a` loads RAM[0x21].
- `MonAReg=0xFF`, then `ocimem_b` → write lands at 0xFF and `MonAReg` wraps to 0x00.
- CPU read issued in the same cycle as an `ocimem_b` strobe → `waitrequest` held for 2 cycles; the CPU receives correct data; the JTAG write is not lost.
- CPU writes 0x3 to the control register → `monitor_ready=1`, `monitor_error=1`. Then `ocimem_a` with `jdo[34]=1` → ready clears, error stays set. A same-cycle CPU set and JTAG clear leaves the bit at 1.
- Assert `reset_n` low during `C_RD` → `waitrequest=0`, `readdata=0`, `MonDReg=0`, flags 0 on the next sample.

Source files
------------

// File: rtl/nios_sys_nios2_cpu_debug_mon_mem.sv
// Debug monitor RAM (256x32) shared by the JTAG debug slave and a CPU Avalon-MM slave, plus ready/error flags.
// JTAG reads land in MonDReg two cycles after the strobe; CPU reads complete in 2 cycles, RAM writes in 1.
// JTAG strobes always win the RAM port; a colliding CPU RAM access is held off with waitrequest and retried.
module nios_sys_nios2_cpu_debug_mon_mem #(
    parameter int RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic [8:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);

    typedef enum logic {C_IDLE, C_RD} cpu_state_t;

    cpu_state_t  state;
    logic [7:0]  mon_a_reg;
    logic        ram_owner;
    logic        rd_ctrl;
    logic [31:0] rd_hold;
    logic [31:0] mem [RAM_WORDS];
    logic [31:0] ram_q;

    logic        jtag_a, jtag_na, jtag_b, jtag_any, jtag_rd;
    logic [7:0]  jtag_rd_addr;
    logic        cpu_rd_issue, cpu_ram_rd, cpu_ram_wr, cpu_ctl_wr;
    logic [31:0] cpu_rd_data;
    logic        unused_jdo_bits;

    assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

    // Strobe priority: b > a > no_action_a.
    always_comb begin
        jtag_b       = take_action_ocimem_b;
        jtag_a       = take_action_ocimem_a & ~take_action_ocimem_b;
        jtag_na      = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
        jtag_any     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        jtag_rd      = (jtag_a & jdo[17]) | jtag_na;
        jtag_rd_addr = jtag_a ? jdo[25:18] : mon_a_reg;
    end

    always_comb begin
        cpu_rd_issue = (state == C_IDLE) & read & ~jtag_any;
        cpu_ram_rd   = cpu_rd_issue & ~address[8];
        cpu_ram_wr   = (state == C_IDLE) & write & ~read & ~address[8] & ~jtag_any;
        cpu_ctl_wr   = (state == C_IDLE) & write & ~read & address[8];
        cpu_rd_data  = rd_ctrl ? {30'b0, monitor_error, monitor_ready} : ram_q;
    end

    always_comb begin
        waitrequest = 1'b0;
        if (state == C_IDLE) begin
            if (read)
                waitrequest = 1'b1;
            else if (write && !address[8] && jtag_any)
                waitrequest = 1'b1;
        end
    end

    // CPU data is valid straight from the RAM output register in C_RD, then held.
    assign readdata = (state == C_RD) ? cpu_rd_data : rd_hold;

    // Single-port RAM; content is deliberately not reset.
    always_ff @(posedge clk) begin
        if (jtag_b) begin
            mem[mon_a_reg] <= jdo[34:3];
        end else if (cpu_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i])
                    mem[address[7:0]][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
        if (jtag_rd)
            ram_q <= mem[jtag_rd_addr];
        else if (cpu_ram_rd)
            ram_q <= mem[address[7:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= C_IDLE;
            mon_a_reg     <= 8'h00;
            ram_owner     <= 1'b0;
            rd_ctrl       <= 1'b0;
            rd_hold       <= 32'h0;
            MonDReg       <= 32'h0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            ram_owner <= jtag_rd;
            if (ram_owner)
                MonDReg <= ram_q;

            if (jtag_b)
                mon_a_reg <= mon_a_reg + 8'd1;
            else if (jtag_a)
                mon_a_reg <= jdo[17] ? jdo[25:18] + 8'd1 : jdo[25:18];
            else if (jtag_na)
                mon_a_reg <= mon_a_reg + 8'd1;

            // A CPU set beats a same-cycle JTAG clear.
            if (cpu_ctl_wr && writedata[0])
                monitor_ready <= 1'b1;
            else if (jtag_a && jdo[34])
                monitor_ready <= 1'b0;
            if (cpu_ctl_wr && writedata[1])
                monitor_error <= 1'b1;
            else if (jtag_a && jdo[35])
                monitor_error <= 1'b0;

            case (state)
                C_IDLE: begin
                    if (cpu_rd_issue) begin
                        state   <= C_RD;
                        rd_ctrl <= address[8];
                    end
                end
                C_RD: begin
                    state   <= C_IDLE;
                    rd_hold <= cpu_rd_data;
                end
                default: state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_sys_nios2_cpu_debug_mon_mem.sv
// Directed bench for the debug monitor memory: reference RAM/flag model with queued expected read data.
module tb_nios_sys_nios2_cpu_debug_mon_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [8:0]  address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    nios_sys_nios2_cpu_debug_mon_mem #(.RAM_WORDS(256)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .waitrequest(waitrequest),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] mem_m [256];
    logic [7:0]  mon_a_m;
    logic        rdy_m, err_m;
    logic [31:0] mondreg_m;
    logic [31:0] cpu_q [$];
    logic [31:0] jtag_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic jtag_a(input logic [7:0] addr, input logic rd, input logic clr_rdy, input logic clr_err);
        jdo = '0;
        jdo[25:18] = addr;
        jdo[17] = rd;
        jdo[34] = clr_rdy;
        jdo[35] = clr_err;
        take_action_ocimem_a = 1'b1;
        if (rd) jtag_q.push_back(mem_m[addr]);
        mon_a_m = rd ? addr + 8'd1 : addr;
        if (clr_rdy) rdy_m = 1'b0;
        if (clr_err) err_m = 1'b0;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_na();
        take_no_action_ocimem_a = 1'b1;
        jtag_q.push_back(mem_m[mon_a_m]);
        mon_a_m = mon_a_m + 8'd1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] dat);
        jdo = {3'b000, dat, 3'b000};
        take_action_ocimem_b = 1'b1;
        mem_m[mon_a_m] = dat;
        mon_a_m = mon_a_m + 8'd1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
    endtask

    // Called right after a JTAG read strobe: MonDReg must still be old, then update a cycle later.
    task automatic jtag_capture(input string tag);
        chk({tag, "_early"}, MonDReg, mondreg_m);
        @(negedge clk);
        if (jtag_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            mondreg_m = jtag_q.pop_front();
            chk(tag, MonDReg, mondreg_m);
        end
    endtask

    task automatic cpu_read(input string tag, input logic [8:0] addr, input logic with_b,
                            input logic [31:0] bdat, input int exp_waits);
        int  waits = 0;
        bit  done  = 0;
        if (with_b) begin
            jdo = {3'b000, bdat, 3'b000};
            take_action_ocimem_b = 1'b1;
            mem_m[mon_a_m] = bdat;
            mon_a_m = mon_a_m + 8'd1;
        end
        cpu_q.push_back(addr[8] ? {30'b0, err_m, rdy_m} : mem_m[addr[7:0]]);
        address = addr;
        read = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!waitrequest) begin
                chk({tag, "_data"}, readdata, cpu_q.pop_front());
                done = 1;
            end else begin
                waits++;
            end
            @(negedge clk);
            take_action_ocimem_b = 1'b0;
        end
        read = 1'b0;
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk({tag, "_waits"}, waits, exp_waits);
    endtask

    task automatic cpu_write(input string tag, input logic [8:0] addr, input logic [31:0] dat,
                             input logic [3:0] be);
        bit done = 0;
        address = addr;
        writedata = dat;
        byteenable = be;
        write = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!waitrequest) begin
                done = 1;
                if (addr[8]) begin
                    if (dat[0]) rdy_m = 1'b1;
                    if (dat[1]) err_m = 1'b1;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mem_m[addr[7:0]][8*b +: 8] = dat[8*b +: 8];
                end
            end
            @(negedge clk);
        end
        write = 1'b0;
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
        address = '0; read = 0; write = 0; writedata = '0; byteenable = '0;
        mon_a_m = 8'h00; rdy_m = 0; err_m = 0; mondreg_m = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_ready", {31'b0, monitor_ready}, 32'h0);
        chk("rst_error", {31'b0, monitor_error}, 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_waitrequest", {31'b0, waitrequest}, 32'h0);
        chk("rst_mon_a", {24'b0, dut.mon_a_reg}, 32'h0);
        @(negedge clk);

        // JTAG write then CPU read-back
        jtag_a(8'h10, 1'b0, 1'b0, 1'b0);
        chk("mon_a_set", {24'b0, dut.mon_a_reg}, {24'b0, mon_a_m});
        jtag_b(32'hDEADBEEF);
        chk("mon_a_inc", {24'b0, dut.mon_a_reg}, {24'b0, mon_a_m});
        cpu_read("cpu_rd_10", 9'h010, 1'b0, 32'h0, 1);

        // CPU writes, JTAG reads
        cpu_write("cpu_wr_20", 9'h020, 32'h12345678, 4'hF);
        cpu_write("cpu_wr_21", 9'h021, 32'hAABBCCDD, 4'hF);
        cpu_write("cpu_wr_21be", 9'h021, 32'h11223344, 4'b0101);
        jtag_a(8'h20, 1'b1, 1'b0, 1'b0);
        jtag_capture("jtag_rd_20");
        chk("mon_a_rd", {24'b0, dut.mon_a_reg}, {24'b0, mon_a_m});
        jtag_na();
        jtag_capture("jtag_na_21");
        chk("mon_a_na", {24'b0, dut.mon_a_reg}, {24'b0, mon_a_m});

        // Address wrap
        jtag_a(8'hFF, 1'b0, 1'b0, 1'b0);
        jtag_b(32'hCAFEF00D);
        chk("mon_a_wrap", {24'b0, dut.mon_a_reg}, {24'b0, mon_a_m});
        cpu_read("cpu_rd_ff", 9'h0FF, 1'b0, 32'h0, 1);

        // CPU read colliding with a JTAG write
        cpu_read("cpu_rd_conflict", 9'h010, 1'b1, 32'h0BADC0DE, 2);
        cpu_read("cpu_rd_00", 9'h000, 1'b0, 32'h0, 1);
        chk("mon_a_conflict", {24'b0, dut.mon_a_reg}, {24'b0, mon_a_m});

        // Control register
        cpu_write("ctl_wr", 9'h100, 32'h3, 4'hF);
        chk("ctl_ready_set", {31'b0, monitor_ready}, {31'b0, rdy_m});
        chk("ctl_error_set", {31'b0, monitor_error}, {31'b0, err_m});
        cpu_read("ctl_rd", 9'h100, 1'b0, 32'h0, 1);
        jtag_a(8'h00, 1'b0, 1'b1, 1'b0);
        chk("ctl_ready_clr", {31'b0, monitor_ready}, {31'b0, rdy_m});
        chk("ctl_error_kept", {31'b0, monitor_error}, {31'b0, err_m});
        // same-cycle CPU set and JTAG clear of ready
        address = 9'h100; writedata = 32'h1; byteenable = 4'hF; write = 1'b1;
        jdo = '0; jdo[34] = 1'b1; take_action_ocimem_a = 1'b1;
        #1;
        chk("ctl_wr_nostall", {31'b0, waitrequest}, 32'h0);
        @(negedge clk);
        write = 1'b0; take_action_ocimem_a = 1'b0;
        rdy_m = 1'b1; mon_a_m = 8'h00;
        chk("set_beats_clr", {31'b0, monitor_ready}, 32'h1);

        // Reset during C_RD
        address = 9'h010; read = 1'b1;
        @(negedge clk);
        #1;
        chk("crd_wait_low", {31'b0, waitrequest}, 32'h0);
        reset_n = 1'b0; read = 1'b0;
        #1;
        rdy_m = 0; err_m = 0; mon_a_m = 8'h00; mondreg_m = '0;
        chk("mid_rst_wait", {31'b0, waitrequest}, 32'h0);
        chk("mid_rst_readdata", readdata, 32'h0);
        chk("mid_rst_MonDReg", MonDReg, 32'h0);
        chk("mid_rst_ready", {31'b0, monitor_ready}, 32'h0);
        chk("mid_rst_error", {31'b0, monitor_error}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cpu_read("post_rst_rd", 9'h010, 1'b0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
